m1_sequencer: RTL and testbench

M1_SEQUENCER -- requirements
Module: m1_sequencer

---
 rtl/m1_sequencer_if.sv | 25 ++
 rtl/m1_sequencer.sv | 144 ++++++++++++++
 tb/tb_m1_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/m1_sequencer_if.sv
// Handshake bundle between m1_sequencer (master) and the ticket machine / requester (slave).
// Pure wiring, no latency; the machine side carries no backpressure of its own.
interface m1_sequencer_if;
    logic       start;
    logic       T;
    logic       V;
    logic [1:0] D;
    logic       oT;
    logic       oM;
    logic       oR;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        input  start, T, V, D,
        output oT, oM, oR, busy, done, err, err_code
    );

    modport slave (
        output start, T, V, D,
        input  oT, oM, oR, busy, done, err, err_code
    );
endinterface

// File: rtl/m1_sequencer.sv
// Ticket-machine sequencer: ticket pulse, two coin pulses, registered outputs one cycle after each decision.
// Waits up to TIMEOUT cycles per response; start is ignored while busy (no queuing).
// Define M1_SEQ_AUTOCLR_EN to clear the machine with oR after a successful vend.
module m1_sequencer #(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          R_n,
    m1_sequencer_if.master bus
);

`ifdef M1_SEQ_AUTOCLR_EN
    typedef enum logic [3:0] {
        IDLE, TICK, WAIT_T, COIN1, WAIT_D1, COIN2, WAIT_V, CLR, WAIT_CLR, FIN, FAIL
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, TICK, WAIT_T, COIN1, WAIT_D1, COIN2, WAIT_V, FIN, FAIL
    } state_t;
`endif

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             tmo;

    assign tmo = (cnt == TMO);

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.oT       <= 1'b0;
            bus.oM       <= 1'b0;
            bus.oR       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= 2'b00;
        end else begin
            bus.oT       <= 1'b0;
            bus.oM       <= 1'b0;
            bus.oR       <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= 2'b00;
            // Saturating wait counter; the pulse states below restart it for the next WAIT_*.
            if (!tmo) cnt <= cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= TICK;
                        bus.oT   <= 1'b1;
                        bus.busy <= 1'b1;
                    end
                end
                TICK: begin
                    state <= WAIT_T;
                    cnt   <= '0;
                end
                WAIT_T: begin
                    if (bus.T) begin
                        state  <= COIN1;
                        bus.oM <= 1'b1;
                    end else if (tmo) begin
                        state        <= FAIL;
                        bus.err      <= 1'b1;
                        bus.err_code <= 2'b01;
                        bus.oR       <= 1'b1;
                    end
                end
                COIN1: begin
                    state <= WAIT_D1;
                    cnt   <= '0;
                end
                WAIT_D1: begin
                    if (bus.D == 2'b01) begin
                        state  <= COIN2;
                        bus.oM <= 1'b1;
                    end else if (tmo) begin
                        state        <= FAIL;
                        bus.err      <= 1'b1;
                        bus.err_code <= 2'b10;
                        bus.oR       <= 1'b1;
                    end
                end
                COIN2: begin
                    state <= WAIT_V;
                    cnt   <= '0;
                end
                WAIT_V: begin
                    if (bus.V && bus.D == 2'b10) begin
`ifdef M1_SEQ_AUTOCLR_EN
                        state    <= CLR;
                        bus.oR   <= 1'b1;
`else
                        state    <= FIN;
                        bus.done <= 1'b1;
`endif
                    end else if (tmo) begin
                        state        <= FAIL;
                        bus.err      <= 1'b1;
                        bus.err_code <= 2'b11;
                        bus.oR       <= 1'b1;
                    end
                end
`ifdef M1_SEQ_AUTOCLR_EN
                CLR: begin
                    state <= WAIT_CLR;
                    cnt   <= '0;
                end
                WAIT_CLR: begin
                    // Cleared machine drops its ticket status.
                    if (!bus.T) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                    end else if (tmo) begin
                        state        <= FAIL;
                        bus.err      <= 1'b1;
                        bus.err_code <= 2'b01;
                        bus.oR       <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                FAIL: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m1_sequencer.sv
// Directed bench for m1_sequencer against a small Moore ticket-machine model.
// Output vector layout: {oT, oM, oR, busy, done, err, err_code[1:0]}.
module tb_m1_sequencer;

    logic clk = 1'b0;
    logic R_n = 1'b0;

    m1_sequencer_if bus();

    m1_sequencer #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk (clk),
        .R_n (R_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef M1_SEQ_AUTOCLR_EN
    localparam int PER = 10;
`else
    localparam int PER = 8;
`endif

    // Machine model: iT -> S1 (T=1), iM -> S2 (D=01), iM -> S3 (V=1, D=10); R or mclr -> S0.
    // mode 1: machine dead, T driven by t_force; mode 2: machine never leaves S2.
    logic [1:0] ms = 2'd0;
    logic       mclr = 1'b0;
    logic       t_force = 1'b0;
    int         mode = 0;

    always_ff @(posedge clk) begin
        if (mclr || bus.oR) ms <= 2'd0;
        else if (mode != 1) begin
            if (bus.oT) ms <= 2'd1;
            else if (bus.oM && ms == 2'd1) ms <= 2'd2;
            else if (bus.oM && ms == 2'd2 && mode != 2) ms <= 2'd3;
        end
    end

    assign bus.T = (mode == 1) ? t_force : (ms != 2'd0);
    assign bus.V = (mode != 1) && (ms == 2'd3);
    assign bus.D = (mode == 1) ? 2'b00 :
                   (ms == 2'd2) ? 2'b01 :
                   (ms == 2'd3) ? 2'b10 : 2'b00;

    logic [7:0] ov;
    assign ov = {bus.oT, bus.oM, bus.oR, bus.busy, bus.done, bus.err, bus.err_code};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs on cycle c of a successful transaction (start sampled in cycle 0).
    function automatic logic [7:0] exp_ok(input int c);
        case (c)
            1:       return 8'b1001_0000;
            3, 5:    return 8'b0101_0000;
            2, 4, 6: return 8'b0001_0000;
`ifdef M1_SEQ_AUTOCLR_EN
            7:       return 8'b0011_0000;
            8:       return 8'b0001_0000;
            9:       return 8'b0001_1000;
`else
            7:       return 8'b0001_1000;
`endif
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic run_txn(input string tag, input bit hold);
        for (int c = 1; c <= PER; c++) begin
            tick();
            if (!hold) bus.start = 1'b0;
            check($sformatf("%s_c%0d", tag, c), ov, exp_ok(c));
        end
    endtask

    task automatic clear_machine(input int m);
        mode = m;
        t_force = 1'b0;
        mclr = 1'b1;
        tick();
        mclr = 1'b0;
    endtask

    // Pulse exclusivity and single-cycle width, checked every cycle out of reset.
    logic [2:0] prevp = 3'b000;
    always @(negedge clk) begin
        if (R_n) begin
            check("pulse_onehot", {7'd0, ($countones({bus.oT, bus.oM, bus.oR}) <= 1)}, 8'd1);
            check("pulse_width", {7'd0, ((|prevp) && (|{bus.oT, bus.oM, bus.oR}))}, 8'd0);
        end
        prevp <= {bus.oT, bus.oM, bus.oR};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e;
        bus.start = 1'b0;

        // Reset state, before and across clock edges
        #3;
        check("reset_outs", ov, 8'd0);
        bus.start = 1'b1;
        tick();
        tick();
        check("reset_hold_start_ignored", ov, 8'd0);
        bus.start = 1'b0;
        #2 R_n = 1'b1;
        clear_machine(0);
        check("idle_after_release", ov, 8'd0);

        // Loopback: oT at 1, oM at 3 and 5, done at 7 (9 with auto-clear)
        bus.start = 1'b1;
        run_txn("loop", 1'b0);
`ifdef M1_SEQ_AUTOCLR_EN
        check("loop_machine", {4'd0, bus.T, bus.V, bus.D}, 8'b0000_0000);
`else
        check("loop_machine", {4'd0, bus.T, bus.V, bus.D}, 8'b0000_1110);
`endif

        // T tied low: WAIT_T cycles 2..10 (count 0..8), err code 01 with oR in cycle 11
        clear_machine(1);
        bus.start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 1)       e = 8'b1001_0000;
            else if (c <= 10) e = 8'b0001_0000;
            else if (c == 11) e = 8'b0011_0101;
            else              e = 8'b0000_0000;
            check($sformatf("t_tmo_c%0d", c), ov, e);
        end

        // T arrives exactly on count==TIMEOUT: accepted; then D never arrives -> code 10
        clear_machine(1);
        bus.start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 1)       e = 8'b1001_0000;
            else if (c <= 10) e = 8'b0001_0000;
            else if (c == 11) e = 8'b0101_0000;
            else if (c <= 20) e = 8'b0001_0000;
            else if (c == 21) e = 8'b0011_0110;
            else              e = 8'b0000_0000;
            check($sformatf("t_edge_d_tmo_c%0d", c), ov, e);
            if (c == 10) t_force = 1'b1;
            if (c == 11) t_force = 1'b0;
        end

        // Machine stuck in S2: WAIT_V cycles 6..14, code 11 in cycle 15, never done
        clear_machine(2);
        bus.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            bus.start = 1'b0;
            if (c == 1)               e = 8'b1001_0000;
            else if (c == 3 || c == 5) e = 8'b0101_0000;
            else if (c <= 14)         e = 8'b0001_0000;
            else if (c == 15)         e = 8'b0011_0111;
            else                      e = 8'b0000_0000;
            check($sformatf("v_tmo_c%0d", c), ov, e);
        end

        // Reset while in WAIT_D1, then a clean transaction
        clear_machine(0);
        bus.start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            bus.start = 1'b0;
            check($sformatf("pre_rst_c%0d", c), ov, exp_ok(c));
        end
        #2 R_n = 1'b0;
        #1;
        check("rst_mid_outs", ov, 8'd0);
        tick();
        tick();
        check("rst_mid_hold", ov, 8'd0);
        #2 R_n = 1'b1;
        tick();
        check("rst_release_idle", ov, 8'd0);
        bus.start = 1'b1;
        run_txn("post_rst", 1'b0);

        // start held high: back-to-back transactions with a single IDLE cycle between
        clear_machine(0);
        bus.start = 1'b1;
        run_txn("held1", 1'b1);
        run_txn("held2", 1'b1);
        bus.start = 1'b0;
        tick();
        check("held_stop_idle", ov, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
